// File: rtl/jk_bank_arbiter_pkg.sv
// jk_pkg: JK command encoding and next-state helper shared by the bank arbiter and its cells
package jk_pkg;
  typedef enum logic [1:0] {HOLD = 2'b00, RST = 2'b01, SET = 2'b10, TGL = 2'b11} jk_op_e;
  function automatic logic next_q(jk_op_e op, logic q);
    return op == TGL ? ~q : op == SET ? 1'b1 : op == RST ? 1'b0 : q;
  endfunction
endpackage

// File: rtl/jk_bank_arbiter_if.sv
// jk_bank_arbiter_if: requester-side command bus and arbiter status for the JK bank
interface jk_bank_arbiter_if #(
  parameter int NREQ = 4,
  parameter int NBITS = 8,
  parameter int IW = $clog2(NBITS),
  parameter int GW = $clog2(NREQ)
);
  logic en;
  logic [NREQ-1:0] req, cmd_j, cmd_k, ack;
  logic [NREQ*IW-1:0] cmd_idx;
  logic err, grant_valid, busy;
  logic [GW-1:0] grant_id;
  logic [NBITS-1:0] q;
  modport master(output en, req, cmd_j, cmd_k, cmd_idx, input ack, err, grant_id, grant_valid, q, busy);
  modport slave(input en, req, cmd_j, cmd_k, cmd_idx, output ack, err, grant_id, grant_valid, q, busy);
endinterface

// File: rtl/jk_bank_arbiter_cell.sv
// jk_cell: single JK flop that updates only when written
module jk_cell import jk_pkg::*; (
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  logic j,
  input  logic k,
  output logic q
);
  always_ff @(posedge clk)
    q <= rst ? 1'b0 : we ? next_q(jk_op_e'({j, k}), q) : q;
endmodule

// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: round-robin arbiter applying one requester JK command per cycle to a bank of JK cells
module jk_bank_arbiter import jk_pkg::*; #(
  parameter int NREQ = 4,
  parameter int NBITS = 8,
  parameter int IW = $clog2(NBITS)
) (
  input logic clk,
  input logic rst,
  jk_bank_arbiter_if.slave bus
);
  localparam int GW = $clog2(NREQ);
  logic [NREQ-1:0] elig;
  logic [GW-1:0] ptr, win;
  logic found, gnt, oob;
  logic [IW-1:0] widx;
  logic [NBITS-1:0] we, q;
  // masking on ack stops a still-held request from being granted twice in a row
  assign elig = bus.req & ~bus.ack;
  assign bus.busy = |elig;
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++)
      if (!found && elig[(int'(ptr) + i) % NREQ]) begin
        found = 1'b1;
        win = GW'((int'(ptr) + i) % NREQ);
      end
  end
  assign gnt = bus.en & found;
  assign widx = bus.cmd_idx[win*IW +: IW];
  assign oob = 32'(widx) >= NBITS;
  always_ff @(posedge clk)
    if (rst) begin
      ptr <= '0;
      bus.ack <= '0;
      bus.err <= 1'b0;
      bus.grant_id <= '0;
      bus.grant_valid <= 1'b0;
    end else begin
      bus.ack <= gnt ? NREQ'(1) << win : '0;
      bus.err <= gnt & oob;
      bus.grant_valid <= gnt;
      bus.grant_id <= gnt ? win : bus.grant_id;
      ptr <= !gnt ? ptr : win == GW'(NREQ - 1) ? '0 : win + 1'b1;
    end
  for (genvar i = 0; i < NBITS; i++) begin : g_cell
    assign we[i] = gnt & ~oob & (widx == IW'(i));
    jk_cell u_cell (.clk(clk), .rst(rst), .we(we[i]), .j(bus.cmd_j[win]), .k(bus.cmd_k[win]), .q(q[i]));
  end
  assign bus.q = q;
endmodule
